// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues synchronous ROM reads and hands
// {instr, pc} to decode with stall buffering and redirect squashing. Optional HALT support: FETCH_HALT_EN.
module fetch_unit #(
  parameter int                    ROM_AWIDTH = 8,
  parameter logic [ROM_AWIDTH-1:0] RESET_PC   = '0,
  parameter logic [15:0]           HALT_WORD  = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_stall,
  input  logic                  i_redirect,
  input  logic [ROM_AWIDTH-1:0] i_redirect_pc,
  output logic                  o_rom_rd,
  output logic [ROM_AWIDTH-1:0] o_rom_raddr,
  input  logic [15:0]           i_rom_rdata,
  output logic [15:0]           o_instr,
  output logic                  o_valid,
  output logic [ROM_AWIDTH-1:0] o_pc,
  output logic                  o_halted
);

  localparam logic [ROM_AWIDTH-1:0] PC_LSB  = ROM_AWIDTH'(1);
  localparam logic [ROM_AWIDTH-1:0] PC_STEP = ROM_AWIDTH'(2);

  logic [ROM_AWIDTH-1:0] pc_reg;
  logic [ROM_AWIDTH-1:0] inflight_pc_reg;
  logic [ROM_AWIDTH-1:0] buf_pc_reg;
  logic [15:0]           buf_instr_reg;
  logic                  inflight_reg;
  logic                  buf_valid_reg;
  logic                  halted;
  logic                  halt_set;

  logic                  any_valid;
  logic [15:0]           sel_instr;
  logic [ROM_AWIDTH-1:0] sel_pc;

  // A word captured during a stall takes precedence over the live ROM data.
  always_comb begin
    any_valid = 1'b0;
    sel_instr = '0;
    sel_pc    = '0;
    if (buf_valid_reg) begin
      any_valid = 1'b1;
      sel_instr = buf_instr_reg;
      sel_pc    = buf_pc_reg;
    end else if (inflight_reg) begin
      any_valid = 1'b1;
      sel_instr = i_rom_rdata;
      sel_pc    = inflight_pc_reg;
    end
  end

  assign o_valid     = any_valid & ~i_redirect;
  assign o_instr     = o_valid ? sel_instr : '0;
  assign o_pc        = o_valid ? sel_pc : '0;
  assign o_rom_rd    = rst & ~i_redirect & ~i_stall & ~halted;
  assign o_rom_raddr = pc_reg;
  assign o_halted    = halted;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg          <= RESET_PC & ~PC_LSB;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
      buf_valid_reg   <= 1'b0;
      buf_instr_reg   <= '0;
      buf_pc_reg      <= '0;
    end else if (i_redirect) begin
      pc_reg        <= i_redirect_pc & ~PC_LSB;
      inflight_reg  <= 1'b0;
      buf_valid_reg <= 1'b0;
    end else if (i_stall) begin
      inflight_reg <= 1'b0;
      if (inflight_reg && !buf_valid_reg) begin
        buf_instr_reg <= i_rom_rdata;
        buf_pc_reg    <= inflight_pc_reg;
        buf_valid_reg <= 1'b1;
      end
    end else begin
      buf_valid_reg <= 1'b0;
      // The read issued alongside a HALT word is dropped on arrival.
      inflight_reg  <= ~halted & ~halt_set;
      if (!halted) begin
        pc_reg          <= pc_reg + PC_STEP;
        inflight_pc_reg <= pc_reg;
      end
    end
  end

`ifdef FETCH_HALT_EN
  logic halted_reg;

  assign halt_set = o_valid & ~i_stall & (o_instr == HALT_WORD);
  assign halted   = halted_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halted_reg <= 1'b0;
    end else if (i_redirect) begin
      halted_reg <= 1'b0;
    end else if (halt_set) begin
      halted_reg <= 1'b1;
    end
  end
`else
  assign halt_set = 1'b0;
  assign halted   = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected {pc, instr} pairs are queued per
// scenario and popped whenever decode consumes a word (o_valid & !i_stall).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_stall;
  logic        i_redirect;
  logic [7:0]  i_redirect_pc;
  logic        o_rom_rd;
  logic [7:0]  o_rom_raddr;
  logic [15:0] i_rom_rdata;
  logic [15:0] o_instr;
  logic        o_valid;
  logic [7:0]  o_pc;
  logic        o_halted;

  logic [15:0] rom [0:127];
  logic [23:0] exp_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  // Synchronous ROM: data appears one cycle after the read strobe.
  always_ff @(posedge clk) begin
    if (o_rom_rd) i_rom_rdata <= rom[o_rom_raddr[7:1]];
  end

  fetch_unit #(.ROM_AWIDTH(8), .RESET_PC(8'h00), .HALT_WORD(16'hFFFF)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_stall       (i_stall),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_rom_rd      (o_rom_rd),
    .o_rom_raddr   (o_rom_raddr),
    .i_rom_rdata   (i_rom_rdata),
    .o_instr       (o_instr),
    .o_valid       (o_valid),
    .o_pc          (o_pc),
    .o_halted      (o_halted)
  );

  task automatic test_reset();
    rst = 1'b0; i_stall = 1'b0; i_redirect = 1'b0; i_redirect_pc = 8'h00;
    #2;
    n_cmp++;
    if ({o_rom_rd, o_valid, o_instr, o_pc, o_halted, o_rom_raddr} !== 35'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: rd=%b valid=%b instr=%h pc=%h halted=%b raddr=%h, required all 0",
               o_rom_rd, o_valid, o_instr, o_pc, o_halted, o_rom_raddr);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({o_rom_rd, o_valid, o_rom_raddr} !== {1'b1, 1'b0, 8'h00}) begin
      n_bad++;
      $display("FAIL reset_first_fetch: rd=%b valid=%b raddr=%h, required rd=1 valid=0 raddr=00",
               o_rom_rd, o_valid, o_rom_raddr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    bit v [2] = '{1, 1};
    logic [23:0] e;
    exp_q.push_back({8'h00, 16'h0100});
    exp_q.push_back({8'h02, 16'h0102});
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({o_valid, o_rom_rd} !== {v[c], 1'b1}) begin
        n_bad++;
        $display("FAIL stream_ctl cyc%0d: valid=%b rd=%b, required valid=%b rd=1", c, o_valid, o_rom_rd, v[c]);
      end
      if (o_valid && !i_stall) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL stream_extra: pc=%h instr=%h, required no word", o_pc, o_instr);
        end else begin
          e = exp_q.pop_front();
          if ({o_pc, o_instr} !== e) begin
            n_bad++;
            $display("FAIL stream_word: pc=%h instr=%h, required pc=%h instr=%h", o_pc, o_instr, e[23:16], e[15:0]);
          end
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    bit st [6] = '{1, 1, 1, 0, 0, 0};
    bit r  [6] = '{0, 0, 0, 1, 1, 1};
    logic [23:0] e;
    exp_q.push_back({8'h04, 16'h0104});
    exp_q.push_back({8'h06, 16'h0106});
    exp_q.push_back({8'h08, 16'h0108});
    for (int c = 0; c < 6; c++) begin
      i_stall = st[c];
      @(negedge clk);
      n_cmp++;
      if ({o_valid, o_rom_rd} !== {1'b1, r[c]}) begin
        n_bad++;
        $display("FAIL stall_ctl cyc%0d: valid=%b rd=%b, required valid=1 rd=%b", c, o_valid, o_rom_rd, r[c]);
      end
      if (st[c]) begin
        n_cmp++;
        if ({o_pc, o_instr} !== {8'h04, 16'h0104}) begin
          n_bad++;
          $display("FAIL stall_hold cyc%0d: pc=%h instr=%h, required pc=04 instr=0104", c, o_pc, o_instr);
        end
      end
      if (o_valid && !i_stall) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL stall_extra: pc=%h instr=%h, required no word", o_pc, o_instr);
        end else begin
          e = exp_q.pop_front();
          if ({o_pc, o_instr} !== e) begin
            n_bad++;
            $display("FAIL stall_word: pc=%h instr=%h, required pc=%h instr=%h", o_pc, o_instr, e[23:16], e[15:0]);
          end
        end
      end
      @(posedge clk); #1;
    end
    i_stall = 1'b0;
  endtask

  task automatic test_redirect();
    bit rd [4] = '{1, 0, 0, 0};
    bit v  [4] = '{0, 0, 1, 1};
    bit r  [4] = '{0, 1, 1, 1};
    logic [23:0] e;
    exp_q.push_back({8'h40, 16'h0140});
    exp_q.push_back({8'h42, 16'h0142});
    i_redirect_pc = 8'h41;
    for (int c = 0; c < 4; c++) begin
      i_redirect = rd[c];
      @(negedge clk);
      n_cmp++;
      if ({o_valid, o_rom_rd} !== {v[c], r[c]}) begin
        n_bad++;
        $display("FAIL redirect_ctl cyc%0d: valid=%b rd=%b, required valid=%b rd=%b", c, o_valid, o_rom_rd, v[c], r[c]);
      end
      if (!v[c]) begin
        n_cmp++;
        if (o_instr !== 16'h0000) begin
          n_bad++;
          $display("FAIL redirect_bubble cyc%0d: instr=%h, required 0000", c, o_instr);
        end
      end
      if (c == 1) begin
        n_cmp++;
        if (o_rom_raddr !== 8'h40) begin
          n_bad++;
          $display("FAIL redirect_addr: raddr=%h, required 40", o_rom_raddr);
        end
      end
      if (o_valid && !i_stall) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL redirect_extra: pc=%h instr=%h, required no word", o_pc, o_instr);
        end else begin
          e = exp_q.pop_front();
          if ({o_pc, o_instr} !== e) begin
            n_bad++;
            $display("FAIL redirect_word: pc=%h instr=%h, required pc=%h instr=%h", o_pc, o_instr, e[23:16], e[15:0]);
          end
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall_redirect_wrap();
    bit          st [9] = '{1, 1, 0, 0, 0, 0, 0, 0, 0};
    bit          rd [9] = '{0, 1, 0, 0, 1, 0, 0, 0, 0};
    logic [7:0]  tg [9] = '{8'h00, 8'h10, 8'h00, 8'h00, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00};
    bit          v  [9] = '{1, 0, 0, 1, 0, 0, 1, 1, 1};
    bit          r  [9] = '{0, 0, 1, 1, 0, 1, 1, 1, 1};
    logic [23:0] e;
    exp_q.push_back({8'h10, 16'h0110});
    exp_q.push_back({8'hFE, 16'h01FE});
    exp_q.push_back({8'h00, 16'h0100});
    exp_q.push_back({8'h02, 16'h0102});
    for (int c = 0; c < 9; c++) begin
      i_stall = st[c]; i_redirect = rd[c]; i_redirect_pc = tg[c];
      @(negedge clk);
      n_cmp++;
      if ({o_valid, o_rom_rd} !== {v[c], r[c]}) begin
        n_bad++;
        $display("FAIL stall_redirect_ctl cyc%0d: valid=%b rd=%b, required valid=%b rd=%b", c, o_valid, o_rom_rd, v[c], r[c]);
      end
      if (o_valid && !i_stall) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL stall_redirect_extra: pc=%h instr=%h, required no word", o_pc, o_instr);
        end else begin
          e = exp_q.pop_front();
          if ({o_pc, o_instr} !== e) begin
            n_bad++;
            $display("FAIL stall_redirect_word: pc=%h instr=%h, required pc=%h instr=%h", o_pc, o_instr, e[23:16], e[15:0]);
          end
        end
      end
      @(posedge clk); #1;
    end
    i_stall = 1'b0; i_redirect = 1'b0;
  endtask

  task automatic test_halt();
`ifdef FETCH_HALT_EN
    bit v [11] = '{0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1};
    bit r [11] = '{0, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1};
    bit h [11] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0};
`else
    bit v [11] = '{0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 1};
    bit r [11] = '{0, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1};
    bit h [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
    bit rd [11] = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    logic [23:0] e;
    rom[3] = 16'hFFFF;
    exp_q.push_back({8'h00, 16'h0100});
    exp_q.push_back({8'h02, 16'h0102});
    exp_q.push_back({8'h04, 16'h0104});
    exp_q.push_back({8'h06, 16'hFFFF});
`ifndef FETCH_HALT_EN
    exp_q.push_back({8'h08, 16'h0108});
    exp_q.push_back({8'h0A, 16'h010A});
`endif
    exp_q.push_back({8'h00, 16'h0100});
    i_redirect_pc = 8'h00;
    for (int c = 0; c < 11; c++) begin
      i_redirect = rd[c];
      @(negedge clk);
      n_cmp++;
      if ({o_valid, o_rom_rd, o_halted} !== {v[c], r[c], h[c]}) begin
        n_bad++;
        $display("FAIL halt_ctl cyc%0d: valid=%b rd=%b halted=%b, required valid=%b rd=%b halted=%b",
                 c, o_valid, o_rom_rd, o_halted, v[c], r[c], h[c]);
      end
      if (o_valid && !i_stall) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL halt_extra: pc=%h instr=%h, required no word", o_pc, o_instr);
        end else begin
          e = exp_q.pop_front();
          if ({o_pc, o_instr} !== e) begin
            n_bad++;
            $display("FAIL halt_word: pc=%h instr=%h, required pc=%h instr=%h", o_pc, o_instr, e[23:16], e[15:0]);
          end
        end
      end
      @(posedge clk); #1;
    end
    i_redirect = 1'b0;
    rom[3] = 16'h0106;
  endtask

  task automatic test_reset_midstall();
    logic [23:0] e;
    i_stall = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({o_valid, o_pc} !== {1'b1, 8'h02}) begin
      n_bad++;
      $display("FAIL midstall_buffer: valid=%b pc=%h, required valid=1 pc=02", o_valid, o_pc);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({o_rom_rd, o_valid, o_instr, o_pc, o_halted, o_rom_raddr} !== 35'd0) begin
      n_bad++;
      $display("FAIL midstall_async_clear: rd=%b valid=%b instr=%h pc=%h halted=%b raddr=%h, required all 0",
               o_rom_rd, o_valid, o_instr, o_pc, o_halted, o_rom_raddr);
    end
    @(posedge clk); #1;
    i_stall = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.push_back({8'h00, 16'h0100});
    exp_q.push_back({8'h02, 16'h0102});
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (o_valid !== (c != 0)) begin
        n_bad++;
        $display("FAIL midstall_restart cyc%0d: valid=%b, required %b", c, o_valid, (c != 0));
      end
      if (o_valid && !i_stall) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL midstall_extra: pc=%h instr=%h, required no word", o_pc, o_instr);
        end else begin
          e = exp_q.pop_front();
          if ({o_pc, o_instr} !== e) begin
            n_bad++;
            $display("FAIL midstall_word: pc=%h instr=%h, required pc=%h instr=%h", o_pc, o_instr, e[23:16], e[15:0]);
          end
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 16'h0100 + 16'(2 * i);
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_stall_redirect_wrap();
    test_halt();
    test_reset_midstall();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d words never delivered, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
